// File: rtl/shift_word_serializer_pkg.sv
// Shared encodings for the word serializer that feeds
// the bidirectional serial shift register.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic ORD_MSB_FIRST = 1'b0;
  localparam logic ORD_LSB_FIRST = 1'b1;

  localparam logic DIR_TO_MSB = 1'b0;
  localparam logic DIR_TO_LSB = 1'b1;

  // Register bit emitted on shift step cnt for a given order.
  function automatic int unsigned bit_sel(
    input logic        lsb_first,
    input int unsigned cnt,
    input int unsigned width
  );
    return lsb_first ? cnt : (width - 1 - cnt);
  endfunction

endpackage

// File: rtl/shift_word_serializer.sv
// Parallel-to-serial feeder: one bit per enabled cycle into the
// downstream shift register, MSB- or LSB-first per word.
module shift_word_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb_first,
  input  logic             ser_stall,
  output logic             ser_d,
  output logic             ser_en,
  output logic             ser_dir,
  output logic             word_done,
  output logic             busy
);

  localparam int CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t           r_state;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_order;

  logic [CNTW-1:0]  w_idx;
  logic             w_bit;
  logic             w_shift;
  logic             w_take;

  assign w_idx   = CNTW'(bit_sel(r_order, 32'(r_cnt), WIDTH));
  assign w_bit   = r_shreg[w_idx];
  assign w_shift = (r_state == ST_SHIFT);
  assign w_take  = (r_state == ST_IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_order <= ORD_MSB_FIRST;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_shreg <= in_data;
            r_order <= in_lsb_first;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Stall freezes cnt, so the bit on ser_d stays put.
          if (!ser_stall) begin
            if (r_cnt == LAST) begin
              r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ser_dir tracks the order of the last accepted word,
  // so it is already correct from the first SHIFT cycle.
  assign in_ready  = (r_state == ST_IDLE);
  assign ser_en    = w_shift && !ser_stall;
  assign ser_d     = w_shift && w_bit;
  assign ser_dir   = r_order ? DIR_TO_LSB : DIR_TO_MSB;
  assign word_done = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_shift_word_serializer.sv
// Directed and random checks of the serializer against a
// behavioural downstream register and word scoreboard.
module tb_shift_word_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_lsb_first;
  logic         ser_stall;
  logic         ser_d;
  logic         ser_en;
  logic         ser_dir;
  logic         word_done;
  logic         busy;

  always #5 clk = ~clk;

  shift_word_serializer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_lsb_first (in_lsb_first),
    .ser_stall    (ser_stall),
    .ser_d        (ser_d),
    .ser_en       (ser_en),
    .ser_dir      (ser_dir),
    .word_done    (word_done),
    .busy         (busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Downstream register model and word scoreboard.
  typedef struct {
    logic [W-1:0] d;
    logic         lsb;
  } word_t;

  word_t        q[$];
  logic [W-1:0] ref_reg = '0;
  int           en_cnt  = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
      en_cnt = 0;
    end else begin
      if (ser_en) begin
        if (q.size() > 0)
          chk("ser_dir", 32'(ser_dir), 32'(q[0].lsb));
        if (ser_dir)
          ref_reg = {ser_d, ref_reg[W-1:1]};
        else
          ref_reg = {ref_reg[W-2:0], ser_d};
        en_cnt++;
      end
      if (word_done) begin
        chk("done_pending", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          chk("reg_word", 32'(ref_reg), 32'(q[0].d));
          chk("en_count", 32'(en_cnt), 32'(W));
          void'(q.pop_front());
        end
        en_cnt = 0;
      end
      if (in_valid && in_ready) begin
        word_t w;
        w.d   = in_data;
        w.lsb = in_lsb_first;
        q.push_back(w);
      end
    end
  end

  function automatic logic exp_bit(input logic [W-1:0] d,
                                   input logic lsb,
                                   input int i);
    return lsb ? d[i] : d[W-1-i];
  endfunction

  task automatic run_word(input logic [W-1:0] d,
                          input logic lsb,
                          input int st_at,
                          input int st_len);
    int i;
    int ns;
    int n;
    bit seen;
    i = 0;
    ns = 0;
    n = 0;
    seen = 0;
    in_valid = 1'b1;
    in_data = d;
    in_lsb_first = lsb;
    ser_stall = 1'b0;
    smp();
    chk("ready_idle", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    while (n < 40) begin
      ser_stall = (i == st_at) && (ns < st_len);
      smp();
      n++;
      if (word_done) begin
        seen = 1;
        break;
      end
      chk("ser_d", 32'(ser_d), 32'(exp_bit(d, lsb, i)));
      if (ser_stall) begin
        chk("en_stalled", 32'(ser_en), 32'd0);
        ns++;
      end else begin
        chk("en_active", 32'(ser_en), 32'd1);
        i++;
      end
      cyc();
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_lat", 32'(n), 32'(W + 1 + st_len));
    chk("bits_sent", 32'(i), 32'(W));
    chk("done_not_ready", 32'(in_ready), 32'd0);
    chk("done_no_en", 32'(ser_en), 32'd0);
    chk("done_reg", 32'(ref_reg), 32'(d));
    ser_stall = 1'b0;
    cyc();
    chk("dir_hold", 32'(ser_dir), 32'(lsb));
  endtask

  task automatic wait_done(input string tag, input bit rnd);
    bit seen;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      ser_stall = rnd ? ($urandom_range(0, 99) < 30) : 1'b0;
      smp();
      if (word_done) begin
        seen = 1;
        break;
      end
      cyc();
    end
    chk(tag, 32'(seen), 32'd1);
    ser_stall = 1'b0;
    cyc();
  endtask

  initial begin
    int n;
    bit got;
    rstn = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_lsb_first = 1'b0;
    ser_stall = 1'b0;
    cyc();
    cyc();
    smp();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_en", 32'(ser_en), 32'd0);
    chk("rst_d", 32'(ser_d), 32'd0);
    chk("rst_dir", 32'(ser_dir), 32'd0);
    chk("rst_done", 32'(word_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cyc();
    rstn = 1'b1;
    cyc();

    run_word(4'b1011, 1'b0, -1, 0);
    run_word(4'b1011, 1'b1, -1, 0);
    run_word(4'b0110, 1'b0, 2, 2);

    // Valid held high across two words.
    in_valid = 1'b1;
    in_data = 4'hA;
    in_lsb_first = 1'b0;
    smp();
    chk("held_ready0", 32'(in_ready), 32'd1);
    cyc();
    in_data = 4'h5;
    n = 0;
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      smp();
      n = k;
      if (in_ready) begin
        got = 1;
        break;
      end
      chk("held_busy", 32'(busy), 32'd1);
      cyc();
    end
    chk("held_got", 32'(got), 32'd1);
    chk("held_gap", 32'(n), 32'(W + 2));
    cyc();
    in_valid = 1'b0;
    wait_done("held_done2", 1'b0);

    // Reset in the middle of a word.
    in_valid = 1'b1;
    in_data = 4'hF;
    in_lsb_first = 1'b0;
    smp();
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    smp();
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_en", 32'(ser_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(word_done), 32'd0);
    chk("mid_rst_dir", 32'(ser_dir), 32'd0);
    for (int k = 0; k < W + 2; k++) begin
      cyc();
      smp();
      chk("mid_rst_quiet", 32'(word_done), 32'd0);
    end
    cyc();
    run_word(4'h3, 1'b0, -1, 0);

    // Random words, random order, ~30% stall.
    for (int w = 0; w < 200; w++) begin
      got = 0;
      in_valid = 1'b1;
      in_data = W'($urandom);
      in_lsb_first = 1'($urandom);
      for (int k = 0; k < 20; k++) begin
        ser_stall = ($urandom_range(0, 99) < 30);
        smp();
        if (in_ready) begin
          got = 1;
          break;
        end
        cyc();
      end
      chk("rnd_accept", 32'(got), 32'd1);
      cyc();
      in_valid = 1'b0;
      wait_done("rnd_done", 1'b1);
    end

    cyc();
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
